// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the seven-segment display blocks:
//   - glyph constants {a,b,c,d,e,f,g}, active-high, for 0-F and BLANK
//   - seg7_glyph : nibble + hex_mode -> 7-bit active-high pattern
//   - apply_pol  : converts an active-high bit to the pin polarity
//   - shadow_t   : per-frame snapshot of the display inputs, sized for the
//                  largest supported display (8 digits) and zero-padded
// -----------------------------------------------------------------------------
package display_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b1111110;
  localparam logic [6:0] GLYPH_1     = 7'b0110000;
  localparam logic [6:0] GLYPH_2     = 7'b1101101;
  localparam logic [6:0] GLYPH_3     = 7'b1111001;
  localparam logic [6:0] GLYPH_4     = 7'b0110011;
  localparam logic [6:0] GLYPH_5     = 7'b1011011;
  localparam logic [6:0] GLYPH_6     = 7'b1011111;
  localparam logic [6:0] GLYPH_7     = 7'b1110000;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1111011;
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_B     = 7'b0011111;
  localparam logic [6:0] GLYPH_C     = 7'b1001110;
  localparam logic [6:0] GLYPH_D     = 7'b0111101;
  localparam logic [6:0] GLYPH_E     = 7'b1001111;
  localparam logic [6:0] GLYPH_F     = 7'b1000111;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Snapshot of the display inputs taken at frame start.
  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  blink;
    logic        hex;
    logic        lz;
  } shadow_t;

  localparam shadow_t SHADOW_RST = '{value: 32'd0, dp: 8'd0, blink: 8'd0,
                                     hex: 1'b0, lz: 1'b0};

  // Letters only appear in hex mode; otherwise nibbles above 9 are blank.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] nib,
                                            input logic       hex);
    logic [6:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = hex ? GLYPH_A : GLYPH_BLANK;
      4'hB:    g = hex ? GLYPH_B : GLYPH_BLANK;
      4'hC:    g = hex ? GLYPH_C : GLYPH_BLANK;
      4'hD:    g = hex ? GLYPH_D : GLYPH_BLANK;
      4'hE:    g = hex ? GLYPH_E : GLYPH_BLANK;
      4'hF:    g = hex ? GLYPH_F : GLYPH_BLANK;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // Active-high request -> pin level.
  function automatic logic apply_pol(input logic b, input logic active_low);
    return b ^ active_low;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational nibble to seven-segment decode, active-high {a,b,c,d,e,f,g}.
//   nibble   in  4  digit value
//   hex_mode in  1  1 = A-F show letters, 0 = values above 9 are blank
//   seg      out 7  segment pattern, active-high
// -----------------------------------------------------------------------------
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  assign seg = seg7_glyph(nibble, hex_mode);

endmodule

// File: rtl/multi_digit_display.sv
// -----------------------------------------------------------------------------
// multi_digit_display
// N-digit multiplexed seven-segment scanner. Each digit owns a slot of
// SLOT_CNT cycles: BLANK_CYCLES guard cycles (all off) followed by an on-window
// whose length follows the brightness level. Inputs are snapshotted once per
// frame so a frame never mixes old and new data.
//   clk, rst_n   clock, synchronous active-low reset
//   value        nibble i drives digit i (digit 0 rightmost)
//   dp           decimal point request per digit
//   blink_mask   digits that blink
//   hex_mode     A-F glyphs enabled
//   lz_blank     leading-zero suppression enable
//   brightness   0..15 duty level
//   segments     {a..g}, dp_out, digit_en : registered pin drives
//   frame_start  one-cycle pulse per frame
// -----------------------------------------------------------------------------
module multi_digit_display
  import display_pkg::*;
#(
  parameter int CLK_FREQ         = 50_000,
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_HZ       = 1_000,
  parameter int BLANK_CYCLES     = 2,
  parameter int BLINK_HZ         = 2,
  parameter int SEG_ACTIVE_LOW   = 0,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  output logic [6:0]              segments,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int SLOT_CNT   = CLK_FREQ / REFRESH_HZ / NUM_DIGITS;
  localparam int ACTIVE     = SLOT_CNT - BLANK_CYCLES;
  localparam int BLINK_HALF = CLK_FREQ / (2 * BLINK_HZ);
  localparam int SLOT_W     = $clog2(SLOT_CNT + 1);
  localparam int BLINK_W    = $clog2(BLINK_HALF + 1);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CNT - 1);
  localparam logic [SLOT_W-1:0]  SLOT_ONE   = SLOT_W'(1);
  localparam logic [SLOT_W-1:0]  SLOT_ZERO  = SLOT_W'(0);
  localparam logic [SLOT_W-1:0]  BLANK_L    = SLOT_W'(BLANK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_ZERO = BLINK_W'(0);
  localparam logic [2:0]         IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [31:0]        ACTIVE32   = 32'(ACTIVE);
  localparam logic               SEG_AL     = (SEG_ACTIVE_LOW != 32'sd0);
  localparam logic               DIGIT_AL   = (DIGIT_ACTIVE_LOW != 32'sd0);

  if (ACTIVE < 1) begin : g_bad_slot
    $error("multi_digit_display: slot too short for the guard time");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("multi_digit_display: NUM_DIGITS must be 1..8");
  end

  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  shadow_t               shadow_q, shadow_d;
  logic [SLOT_W-1:0]     on_q, on_d;
  logic [6:0]            segments_q, segments_d;
  logic                  dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_start_q, frame_start_d;

  logic                  frame_start_s;
  logic [7:0]            supp_s;
  logic                  in_win_s;
  logic                  lit_s;
  logic [3:0]            nibble_s;
  logic [6:0]            glyph_s;

  assign frame_start_s = (slot_cnt_q == SLOT_ZERO) && (idx_q == 3'd0);
  assign nibble_s      = shadow_q.value[{idx_q, 2'b00} +: 4];

  seg7_decoder u_seg7_decoder (
    .nibble   (nibble_s),
    .hex_mode (shadow_q.hex),
    .seg      (glyph_s)
  );

  // Slot counter, digit index and blink timebase.
  always_comb begin
    slot_cnt_d    = slot_cnt_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = SLOT_ZERO;
      if (idx_q == IDX_LAST) begin
        idx_d = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      slot_cnt_d = slot_cnt_q + SLOT_ONE;
    end
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = BLINK_ZERO;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_ONE;
    end
  end

  // Frame snapshot; the on-window length is fixed for the whole frame.
  always_comb begin
    shadow_d = shadow_q;
    on_d     = on_q;
    if (frame_start_s) begin
      shadow_d.value = 32'(value);
      shadow_d.dp    = 8'(dp);
      shadow_d.blink = 8'(blink_mask);
      shadow_d.hex   = hex_mode;
      shadow_d.lz    = lz_blank;
      on_d           = SLOT_W'((ACTIVE32 * ({28'd0, brightness} + 32'd1)) >> 4);
    end else begin
      shadow_d = shadow_q;
      on_d     = on_q;
    end
  end

  // Leading-zero suppression: a digit goes dark while it and every digit to
  // its left hold zero with no decimal point. Digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    supp_s   = 8'd0;
    for (int i = 7; i >= 1; i--) begin
      zero_run  = zero_run && (shadow_q.value[4*i +: 4] == 4'd0) && !shadow_q.dp[i];
      supp_s[i] = shadow_q.lz && zero_run;
    end
  end

  // Lit decision and pin-level output values.
  always_comb begin
    in_win_s = (slot_cnt_q >= BLANK_L) &&
               ({1'b0, slot_cnt_q} < ({1'b0, BLANK_L} + {1'b0, on_q}));
    lit_s    = in_win_s && !supp_s[idx_q] &&
               !(blink_phase_q && shadow_q.blink[idx_q]);
    for (int s = 0; s < 7; s++) begin
      segments_d[s] = apply_pol(lit_s && glyph_s[s], SEG_AL);
    end
    dp_out_d = apply_pol(lit_s && shadow_q.dp[idx_q], SEG_AL);
    for (int d = 0; d < NUM_DIGITS; d++) begin
      digit_en_d[d] = apply_pol(lit_s && (idx_q == 3'(d)), DIGIT_AL);
    end
    frame_start_d = frame_start_s;
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_q    <= SLOT_ZERO;
      idx_q         <= 3'd0;
      blink_cnt_q   <= BLINK_ZERO;
      blink_phase_q <= 1'b0;
      shadow_q      <= SHADOW_RST;
      on_q          <= SLOT_ZERO;
      segments_q    <= {7{SEG_AL}};
      dp_out_q      <= SEG_AL;
      digit_en_q    <= {NUM_DIGITS{DIGIT_AL}};
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shadow_q      <= shadow_d;
      on_q          <= on_d;
      segments_q    <= segments_d;
      dp_out_q      <= dp_out_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign segments    = segments_q;
  assign dp_out      = dp_out_q;
  assign digit_en    = digit_en_q;
  assign frame_start = frame_start_q;

endmodule
